// File: rtl/twi_pipe_param.sv
// Parameterised twiddle/sideband delay pipe: {valid, BN, MA} delayed SB_DEPTH
// enabled cycles, RADIX twiddle channels delayed TWI_DEPTH enabled cycles.
module twi_pipe_param #(
  parameter int A_WIDTH   = 11,
  parameter int P_WIDTH   = 64,
  parameter int RADIX     = 16,
  parameter int SB_DEPTH  = 5,
  parameter int TWI_DEPTH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       valid_in,
  input  logic                       BN_in,
  input  logic [A_WIDTH-1:0]         MA_in,
  input  logic [RADIX*P_WIDTH-1:0]   TWI_in,
  output logic                       valid_out,
  output logic                       BN_out,
  output logic [A_WIDTH-1:0]         MA_out,
  output logic [RADIX*P_WIDTH-1:0]   TWI_out,
  output logic                       primed
);

  localparam int TW    = RADIX * P_WIDTH;
  localparam int CNT_W = $clog2(SB_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SB_DEPTH);

  // Handshake: there is no backpressure. A sample is taken whenever en=1 and
  // flush=0 at a rising edge; valid_out qualifies BN_out/MA_out only.

  logic [SB_DEPTH-1:0]               sb_valid;
  logic [SB_DEPTH-1:0]               sb_bn;
  logic [SB_DEPTH-1:0][A_WIDTH-1:0]  sb_ma;
  logic [TWI_DEPTH-1:0][TW-1:0]      twi_q;
  logic [CNT_W-1:0]                  fill_cnt;
  logic                              primed_q;

  // Sideband shift register; flush wipes it regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid <= '0;
      sb_bn    <= '0;
      sb_ma    <= '0;
    end else if (flush) begin
      sb_valid <= '0;
      sb_bn    <= '0;
      sb_ma    <= '0;
    end else if (en) begin
      sb_valid[0] <= valid_in;
      sb_bn[0]    <= BN_in;
      sb_ma[0]    <= MA_in;
      for (int i = 1; i < SB_DEPTH; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_bn[i]    <= sb_bn[i-1];
        sb_ma[i]    <= sb_ma[i-1];
      end
    end
  end

  // Twiddle shift register; a flush edge neither clears nor advances it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      twi_q <= '0;
    end else if (en && !flush) begin
      twi_q[0] <= TWI_in;
      for (int i = 1; i < TWI_DEPTH; i++) begin
        twi_q[i] <= twi_q[i-1];
      end
    end
  end

  // Fill counter saturates at SB_DEPTH; primed is its registered "full" flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
      primed_q <= 1'b0;
    end else if (flush) begin
      fill_cnt <= '0;
      primed_q <= 1'b0;
    end else if (en && (fill_cnt != FULL)) begin
      fill_cnt <= fill_cnt + 1'b1;
      primed_q <= ((fill_cnt + 1'b1) == FULL);
    end
  end

  assign valid_out = sb_valid[SB_DEPTH-1];
  assign BN_out    = sb_bn[SB_DEPTH-1];
  assign MA_out    = sb_ma[SB_DEPTH-1];
  assign TWI_out   = twi_q[TWI_DEPTH-1];
  assign primed    = primed_q;

endmodule
